// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator driven by a command/response stream,
// with a sticky per-transaction watchdog that flags slaves which never respond.
module axi_lite_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [2:0]          cmd_prot,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                timeout_err,
    output logic [ADDR_W-1:0]   write_addr,
    output logic [2:0]          write_prot,
    output logic                write_addr_valid,
    input  logic                write_addr_ready,
    output logic [DATA_W-1:0]   write_data,
    output logic [DATA_W/8-1:0] write_strb,
    output logic                write_data_valid,
    input  logic                write_data_ready,
    input  logic [1:0]          write_resp,
    input  logic                write_resp_valid,
    output logic                write_resp_ready,
    output logic [ADDR_W-1:0]   read_addr,
    output logic [2:0]          read_prot,
    output logic                read_addr_valid,
    input  logic                read_addr_ready,
    input  logic [DATA_W-1:0]   read_data,
    input  logic [1:0]          read_resp,
    input  logic                read_data_valid,
    output logic                read_data_ready
);
    localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

    state_t              state, state_n;
    logic                aw_done, w_done, aw_hs, w_hs, accept, busy;
    logic [15:0]         wd_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          prot_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;

    assign write_addr = addr_q;
    assign read_addr  = addr_q;
    assign write_prot = prot_q;
    assign read_prot  = prot_q;
    assign write_data = wdata_q;
    assign write_strb = wstrb_q;
    assign aw_hs      = write_addr_valid & write_addr_ready;
    assign w_hs       = write_data_valid & write_data_ready;
    assign accept     = (state == IDLE) & cmd_valid;
    assign busy       = state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;

    // Valids derive only from registered state, never from the ready inputs.
    always_comb begin
        state_n          = state;
        cmd_ready        = 1'b0;
        rsp_valid        = 1'b0;
        write_addr_valid = 1'b0;
        write_data_valid = 1'b0;
        write_resp_ready = 1'b0;
        read_addr_valid  = 1'b0;
        read_data_ready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_n = cmd_write ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                write_addr_valid = !aw_done;
                write_data_valid = !w_done;
                if ((aw_done | aw_hs) & (w_done | w_hs)) state_n = WR_RESP;
            end
            WR_RESP: begin
                write_resp_ready = 1'b1;
                if (write_resp_valid) state_n = RSP;
            end
            RD_REQ: begin
                read_addr_valid = 1'b1;
                if (read_addr_ready) state_n = RD_DATA;
            end
            RD_DATA: begin
                read_data_ready = 1'b1;
                if (read_data_valid) state_n = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            addr_q      <= '0;
            prot_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                addr_q      <= cmd_addr;
                prot_q      <= cmd_prot;
                wdata_q     <= cmd_wdata;
                wstrb_q     <= cmd_wstrb;
                rsp_write   <= cmd_write;
                aw_done     <= 1'b0;
                w_done      <= 1'b0;
                wd_cnt      <= '0;
                timeout_err <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            // Flag is raised in the same cycle the count reaches the limit.
            if (busy) begin
                if (wd_cnt != 16'hFFFF) wd_cnt <= wd_cnt + 16'd1;
                if (TIMEOUT != 16'd0 && wd_cnt + 16'd1 == TIMEOUT) timeout_err <= 1'b1;
            end
            if (state == WR_RESP && write_resp_valid) begin
                rsp_resp  <= write_resp;
                rsp_rdata <= '0;
            end
            if (state == RD_DATA && read_data_valid) begin
                rsp_resp  <= read_resp;
                rsp_rdata <= read_data;
            end
        end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed cycle-accurate checks of the AXI4-Lite initiator
// (watchdog limit reduced to 8 cycles).
module tb_axi_lite_master;
    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_prot;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout_err;
    logic [31:0] write_addr, write_data, read_addr, read_data;
    logic [2:0]  write_prot, read_prot;
    logic [3:0]  write_strb;
    logic        write_addr_valid, write_addr_ready, write_data_valid, write_data_ready;
    logic [1:0]  write_resp, read_resp;
    logic        write_resp_valid, write_resp_ready;
    logic        read_addr_valid, read_addr_ready, read_data_valid, read_data_ready;
    int          tests = 0;
    int          fails = 0;

    axi_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
        .write_addr(write_addr), .write_prot(write_prot), .write_addr_valid(write_addr_valid),
        .write_addr_ready(write_addr_ready), .write_data(write_data), .write_strb(write_strb),
        .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
        .write_resp(write_resp), .write_resp_valid(write_resp_valid), .write_resp_ready(write_resp_ready),
        .read_addr(read_addr), .read_prot(read_prot), .read_addr_valid(read_addr_valid),
        .read_addr_ready(read_addr_ready), .read_data(read_data), .read_resp(read_resp),
        .read_data_valid(read_data_valid), .read_data_ready(read_data_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Presents a command at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_prot = p;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); end
        tests++; if ({write_addr_valid, write_data_valid, read_addr_valid, write_resp_ready, read_data_ready, rsp_valid, timeout_err} !== 7'b0)
            begin fails++; $display("FAIL reset valids: got %b want 0", {write_addr_valid, write_data_valid, read_addr_valid, write_resp_ready, read_data_ready, rsp_valid, timeout_err}); end
        tests++; if ({rsp_rdata, rsp_resp, write_addr} !== 66'b0) begin fails++; $display("FAIL reset regs: got %h want 0", {rsp_rdata, rsp_resp, write_addr}); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        write_addr_ready = 1'b1; write_data_ready = 1'b1; write_resp_valid = 1'b1; write_resp = 2'b00; rsp_ready = 1'b1;
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010);
        tests++; if ({write_addr_valid, write_data_valid, cmd_ready} !== 3'b110) begin fails++; $display("FAIL wr c1 valids: got %b want 110", {write_addr_valid, write_data_valid, cmd_ready}); end
        tests++; if ({write_addr, write_data, write_strb, write_prot} !== {32'h10, 32'hDEAD_BEEF, 4'hF, 3'b010})
            begin fails++; $display("FAIL wr c1 payload: got %h %h %h %h", write_addr, write_data, write_strb, write_prot); end
        @(negedge clk);
        tests++; if ({write_addr_valid, write_data_valid, write_resp_ready, rsp_valid} !== 4'b0010) begin fails++; $display("FAIL wr c2 bready: got %b want 0010", {write_addr_valid, write_data_valid, write_resp_ready, rsp_valid}); end
        @(negedge clk); write_resp_valid = 1'b0;
        tests++; if ({rsp_valid, rsp_write, rsp_resp} !== 4'b1100) begin fails++; $display("FAIL wr c3 rsp: got %b want 1100", {rsp_valid, rsp_write, rsp_resp}); end
        tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL wr c3 rdata: got %h want 0", rsp_rdata); end
        @(negedge clk);
        tests++; if ({cmd_ready, rsp_valid} !== 2'b10) begin fails++; $display("FAIL wr c4 idle: got %b want 10", {cmd_ready, rsp_valid}); end
    endtask

    task automatic test_skew;
        write_addr_ready = 1'b0; write_data_ready = 1'b1;
        send(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'h3, 3'b000);
        tests++; if ({write_addr_valid, write_data_valid} !== 2'b11) begin fails++; $display("FAIL skew c1: got %b want 11", {write_addr_valid, write_data_valid}); end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            tests++; if ({write_addr_valid, write_data_valid, write_resp_ready} !== 3'b100)
                begin fails++; $display("FAIL skew c%0d: got %b want 100", c, {write_addr_valid, write_data_valid, write_resp_ready}); end
        end
        write_addr_ready = 1'b1;
        @(negedge clk);
        tests++; if ({write_addr_valid, write_data_valid, write_resp_ready} !== 3'b001) begin fails++; $display("FAIL skew c5: got %b want 001", {write_addr_valid, write_data_valid, write_resp_ready}); end
        write_resp_valid = 1'b1; write_resp = 2'b10;
        @(negedge clk); write_resp_valid = 1'b0;
        tests++; if ({rsp_valid, rsp_resp, timeout_err} !== 4'b1100) begin fails++; $display("FAIL skew c6 rsp: got %b want 1100", {rsp_valid, rsp_resp, timeout_err}); end
        @(negedge clk);
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL skew c7 cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_read;
        read_addr_ready = 1'b1; read_data_valid = 1'b0;
        send(1'b0, 32'h0000_0004, 32'h0, 4'h0, 3'b001);
        tests++; if ({read_addr_valid, read_data_ready, write_addr_valid, write_data_valid} !== 4'b1000)
            begin fails++; $display("FAIL rd c1 valids: got %b want 1000", {read_addr_valid, read_data_ready, write_addr_valid, write_data_valid}); end
        tests++; if ({read_addr, read_prot} !== {32'h4, 3'b001}) begin fails++; $display("FAIL rd c1 addr: got %h %b", read_addr, read_prot); end
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            tests++; if ({read_addr_valid, read_data_ready, rsp_valid} !== 3'b010)
                begin fails++; $display("FAIL rd wait c%0d: got %b want 010", c, {read_addr_valid, read_data_ready, rsp_valid}); end
        end
        read_data_valid = 1'b1; read_data = 32'h1234_5678; read_resp = 2'b10;
        @(negedge clk); read_data_valid = 1'b0;
        tests++; if ({rsp_valid, rsp_write, rsp_resp} !== 4'b1010) begin fails++; $display("FAIL rd rsp: got %b want 1010", {rsp_valid, rsp_write, rsp_resp}); end
        tests++; if (rsp_rdata !== 32'h1234_5678) begin fails++; $display("FAIL rd rdata: got %h want 12345678", rsp_rdata); end
        @(negedge clk);
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rd idle: got %b want 1", cmd_ready); end
    endtask

    task automatic test_watchdog;
        read_addr_ready = 1'b1; read_data_valid = 1'b0;
        send(1'b0, 32'h0000_0008, 32'h0, 4'h0, 3'b000);
        repeat (7) @(negedge clk);
        tests++; if ({timeout_err, read_data_ready} !== 2'b01) begin fails++; $display("FAIL wd c8: got %b want 01", {timeout_err, read_data_ready}); end
        @(negedge clk);
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL wd c9 rise: got %b want 1", timeout_err); end
        repeat (11) @(negedge clk);
        tests++; if ({timeout_err, read_data_ready, rsp_valid} !== 3'b110) begin fails++; $display("FAIL wd c20 waiting: got %b want 110", {timeout_err, read_data_ready, rsp_valid}); end
        read_data_valid = 1'b1; read_data = 32'hCAFE_0001; read_resp = 2'b00;
        @(negedge clk); read_data_valid = 1'b0;
        tests++; if ({rsp_valid, rsp_resp, timeout_err, rsp_rdata} !== {1'b1, 2'b00, 1'b1, 32'hCAFE_0001})
            begin fails++; $display("FAIL wd rsp: got %b %b %b %h", rsp_valid, rsp_resp, timeout_err, rsp_rdata); end
        @(negedge clk);
        tests++; if ({cmd_ready, timeout_err} !== 2'b11) begin fails++; $display("FAIL wd sticky: got %b want 11", {cmd_ready, timeout_err}); end
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0; write_addr_ready = 1'b1; write_data_ready = 1'b1; write_resp_valid = 1'b1; write_resp = 2'b11;
        send(1'b1, 32'h0000_0030, 32'h0000_0055, 4'h1, 3'b000);
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL bp clear timeout: got %b want 0", timeout_err); end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            tests++; if ({rsp_valid, cmd_ready, write_addr_valid, write_data_valid, write_resp_ready, read_addr_valid, read_data_ready} !== 7'b1000000)
                begin fails++; $display("FAIL bp hold %0d: got %b want 1000000", i, {rsp_valid, cmd_ready, write_addr_valid, write_data_valid, write_resp_ready, read_addr_valid, read_data_ready}); end
            tests++; if ({rsp_write, rsp_resp, rsp_rdata} !== {1'b1, 2'b11, 32'h0})
                begin fails++; $display("FAIL bp rsp %0d: got %b %b %h", i, rsp_write, rsp_resp, rsp_rdata); end
            @(negedge clk);
        end
        write_resp_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        tests++; if ({cmd_ready, rsp_valid} !== 2'b10) begin fails++; $display("FAIL bp release: got %b want 10", {cmd_ready, rsp_valid}); end
    endtask

    task automatic test_back_to_back;
        write_resp_valid = 1'b1; write_resp = 2'b00;
        read_data_valid = 1'b1; read_data = 32'hA5A5_A5A5; read_resp = 2'b00;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h11; cmd_wstrb = 4'hF; cmd_prot = 3'b000;
        @(negedge clk);
        cmd_write = 1'b0; cmd_addr = 32'h44;
        tests++; if ({cmd_ready, write_addr_valid, write_addr, write_data} !== {2'b01, 32'h40, 32'h11})
            begin fails++; $display("FAIL b2b wr latch: got %b %h %h", cmd_ready, write_addr, write_data); end
        repeat (2) @(negedge clk);
        tests++; if ({rsp_valid, rsp_write, cmd_ready} !== 3'b110) begin fails++; $display("FAIL b2b wr rsp: got %b want 110", {rsp_valid, rsp_write, cmd_ready}); end
        @(negedge clk);
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b c4 cmd_ready: got %b want 1", cmd_ready); end
        @(negedge clk); cmd_valid = 1'b0;
        tests++; if ({read_addr_valid, read_addr} !== {1'b1, 32'h44}) begin fails++; $display("FAIL b2b rd ar: got %b %h", read_addr_valid, read_addr); end
        repeat (2) @(negedge clk);
        read_data_valid = 1'b0; write_resp_valid = 1'b0;
        tests++; if ({rsp_valid, rsp_write, rsp_rdata} !== {2'b10, 32'hA5A5_A5A5}) begin fails++; $display("FAIL b2b rd rsp: got %b %b %h", rsp_valid, rsp_write, rsp_rdata); end
        @(negedge clk);
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b end cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_reset_mid_write;
        write_addr_ready = 1'b0; write_data_ready = 1'b0;
        send(1'b1, 32'h0000_0050, 32'h0000_0077, 4'hF, 3'b000);
        tests++; if ({write_addr_valid, write_data_valid} !== 2'b11) begin fails++; $display("FAIL rst_mid pre: got %b want 11", {write_addr_valid, write_data_valid}); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({write_addr_valid, write_data_valid, write_resp_ready, read_addr_valid, read_data_ready, rsp_valid, cmd_ready} !== 7'b0000001)
            begin fails++; $display("FAIL rst_mid async: got %b want 0000001", {write_addr_valid, write_data_valid, write_resp_ready, read_addr_valid, read_data_ready, rsp_valid, cmd_ready}); end
        tests++; if (write_addr !== 32'h0) begin fails++; $display("FAIL rst_mid addr: got %h want 0", write_addr); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        tests++; if ({cmd_ready, write_addr_valid, write_data_valid} !== 3'b100) begin fails++; $display("FAIL rst_mid release: got %b want 100", {cmd_ready, write_addr_valid, write_data_valid}); end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; cmd_prot = '0;
        rsp_ready = 1'b0;
        write_addr_ready = 1'b0; write_data_ready = 1'b0; write_resp_valid = 1'b0; write_resp = '0;
        read_addr_ready = 1'b0; read_data_valid = 1'b0; read_data = '0; read_resp = '0;
        test_reset;
        test_write;
        test_skew;
        test_read;
        test_watchdog;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_write;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
